// File: rtl/rtc_read_sequencer.sv
// Sweeps 11 RTC timekeeping registers over the multiplexed A/D bus.
// Each captured byte is published to the display register bank as a one-cycle AoD=0 write.
module rtc_read_sequencer #(
    parameter int unsigned PHASE_CYC = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] rtc_ad_in,
    output logic [7:0] rtc_ad_out,
    output logic       rtc_ad_oe,
    output logic       rtc_cs_n,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n,
    output logic       rtc_a_d,
    output logic [7:0] address,
    output logic [7:0] data_vga,
    output logic       AoD,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_GAP1, S_DATA, S_PUB, S_GAP2, S_DONE
    } state_t;

    state_t     r_state;
    logic [3:0] r_idx;
    logic [7:0] r_cnt;
    logic [7:0] r_ad_out;
    logic       r_ad_oe;
    logic       r_cs_n;
    logic       r_rd_n;
    logic       r_wr_n;
    logic       r_a_d;
    logic [7:0] r_address;
    logic [7:0] r_data;
    logic       r_aod;
    logic       r_busy;
    logic       r_done;

    logic       w_last;
    logic [3:0] w_next_idx;

    function automatic logic [7:0] table_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    table_addr = 8'h21;
            4'd1:    table_addr = 8'h22;
            4'd2:    table_addr = 8'h23;
            4'd3:    table_addr = 8'h24;
            4'd4:    table_addr = 8'h25;
            4'd5:    table_addr = 8'h26;
            4'd6:    table_addr = 8'h27;
            4'd7:    table_addr = 8'h28;
            4'd8:    table_addr = 8'h41;
            4'd9:    table_addr = 8'h42;
            4'd10:   table_addr = 8'h43;
            default: table_addr = 8'h00;
        endcase
    endfunction

    assign w_last     = (r_cnt == 8'(PHASE_CYC - 1));
    assign w_next_idx = r_idx + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_ad_out  <= '0;
            r_ad_oe   <= 1'b0;
            r_cs_n    <= 1'b1;
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_a_d     <= 1'b1;
            r_address <= '0;
            r_data    <= '0;
            r_aod     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_aod  <= 1'b1;
            // Multi-cycle phases wrap the counter on their last cycle; single-cycle states override to 0.
            r_cnt  <= w_last ? '0 : r_cnt + 8'd1;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_state   <= S_ADDR;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_cs_n    <= 1'b0;
                        r_wr_n    <= 1'b0;
                        r_a_d     <= 1'b1;
                        r_ad_oe   <= 1'b1;
                        r_ad_out  <= table_addr(4'd0);
                        r_address <= table_addr(4'd0);
                    end
                end
                S_ADDR: begin
                    if (w_last) begin
                        r_state <= S_GAP1;
                        r_cs_n  <= 1'b1;
                        r_wr_n  <= 1'b1;
                        r_ad_oe <= 1'b0;
                    end
                end
                S_GAP1: begin
                    if (w_last) begin
                        r_state <= S_DATA;
                        r_cs_n  <= 1'b0;
                        r_rd_n  <= 1'b0;
                        r_a_d   <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_last) begin
                        r_state <= S_PUB;
                        r_cs_n  <= 1'b1;
                        r_rd_n  <= 1'b1;
                        r_a_d   <= 1'b1;
                        r_data  <= rtc_ad_in;
                        r_aod   <= 1'b0;
                    end
                end
                S_PUB: begin
                    r_state <= S_GAP2;
                    r_cnt   <= '0;
                end
                S_GAP2: begin
                    if (w_last) begin
                        if (r_idx < 4'd10) begin
                            r_state   <= S_ADDR;
                            r_idx     <= w_next_idx;
                            r_cs_n    <= 1'b0;
                            r_wr_n    <= 1'b0;
                            r_ad_oe   <= 1'b1;
                            r_ad_out  <= table_addr(w_next_idx);
                            r_address <= table_addr(w_next_idx);
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rtc_ad_out = r_ad_out;
    assign rtc_ad_oe  = r_ad_oe;
    assign rtc_cs_n   = r_cs_n;
    assign rtc_rd_n   = r_rd_n;
    assign rtc_wr_n   = r_wr_n;
    assign rtc_a_d    = r_a_d;
    assign address    = r_address;
    assign data_vga   = r_data;
    assign AoD        = r_aod;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
